brq_tlul_host_mux: RTL

- Parametrised successor to the per-port TL-UL host adapters in the brq core top.
- Merges NumCh core-side req/gnt/rvalid channels onto one TL-UL host port. Typical channels are instr, data, and a debug/DMA master.
- Arbitration is round-robin, with per-channel outstanding-request limits.
- Responses are routed back by a_source/d_source tagging, so responses may return out of order across channels.

---
 rtl/brq_tlul_host_mux.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/brq_tlul_host_mux.sv
// Round-robin merge of NumCh core-side req/gnt/rvalid channels onto one TL-UL host port.
// Optional sticky protocol-error flag: define BRQ_HOST_MUX_ERRCHK_EN.
module brq_tlul_host_mux #(
    parameter int NumCh   = 2,
    parameter int MaxReqs = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SrcW    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumCh-1:0]      req_i,
    output logic [NumCh-1:0]      gnt_o,
    input  logic [NumCh*AW-1:0]   addr_i,
    input  logic [NumCh-1:0]      we_i,
    input  logic [NumCh*DW-1:0]   wdata_i,
    input  logic [NumCh*DW/8-1:0] be_i,
    output logic [NumCh-1:0]      valid_o,
    output logic [DW-1:0]         rdata_o,
    output logic                  err_o,
    output logic                  a_valid_o,
    input  logic                  a_ready_i,
    output logic [2:0]            a_opcode_o,
    output logic [1:0]            a_size_o,
    output logic [AW-1:0]         a_address_o,
    output logic [DW-1:0]         a_data_o,
    output logic [DW/8-1:0]       a_mask_o,
    output logic [SrcW-1:0]       a_source_o,
    input  logic                  d_valid_i,
    output logic                  d_ready_o,
    input  logic [DW-1:0]         d_data_i,
    input  logic                  d_error_i,
    input  logic [SrcW-1:0]       d_source_i
`ifdef BRQ_HOST_MUX_ERRCHK_EN
    ,
    output logic                  proto_err_o
`endif
);

    localparam int BW       = DW / 8;
    localparam int SlotBits = $clog2(MaxReqs);
    localparam int SlotW    = (SlotBits > 0) ? SlotBits : 1;
    localparam int ChW      = $clog2(NumCh);
    localparam int CntW     = $clog2(MaxReqs + 1);

    typedef enum logic {ST_ARB, ST_LOCK} state_e;

    state_e           state_q;
    logic [ChW-1:0]   lock_ch_q;
    logic [ChW-1:0]   rr_ptr_q;
    logic [CntW-1:0]  cnt_q  [NumCh];
    logic [SlotW-1:0] slot_q [NumCh];

    logic [NumCh-1:0] elig;
    logic [NumCh-1:0] gnt;
    logic [NumCh-1:0] rsp_valid;
    logic [ChW-1:0]   scan_idx;
    logic [ChW-1:0]   arb_ch;
    logic [ChW-1:0]   win_ch;
    logic             any_elig;
    logic             a_valid;
    logic             accept;
    logic [BW-1:0]    win_be;
    logic             win_we;
    logic [SrcW-1:0]  rsp_ch;

    // Scan from rr_ptr downwards in reverse so the closest eligible channel wins last.
    always_comb begin
        elig     = '0;
        arb_ch   = '0;
        any_elig = 1'b0;
        scan_idx = '0;
        for (int c = 0; c < NumCh; c++) begin
            elig[c] = req_i[c] && (cnt_q[c] < CntW'(MaxReqs));
        end
        for (int i = NumCh - 1; i >= 0; i--) begin
            scan_idx = ChW'((int'(rr_ptr_q) + i) % NumCh);
            if (elig[scan_idx]) begin
                arb_ch   = scan_idx;
                any_elig = 1'b1;
            end
        end
    end

    assign win_ch  = (state_q == ST_LOCK) ? lock_ch_q : arb_ch;
    assign a_valid = !rst_i && ((state_q == ST_LOCK) || any_elig);
    assign accept  = a_valid && a_ready_i;
    assign win_we  = we_i[win_ch];
    assign win_be  = be_i[win_ch*BW +: BW];
    assign gnt     = accept ? (NumCh'(1) << win_ch) : '0;

    always_comb begin
        a_opcode_o  = 3'd0;
        a_size_o    = 2'd0;
        a_address_o = '0;
        a_data_o    = '0;
        a_mask_o    = '0;
        a_source_o  = '0;
        if (a_valid) begin
            a_size_o    = 2'($clog2(BW));
            a_address_o = addr_i[win_ch*AW +: AW];
            a_data_o    = wdata_i[win_ch*DW +: DW];
            a_mask_o    = win_we ? win_be : '1;
            a_source_o  = (SrcW'(win_ch) << SlotBits) | SrcW'(slot_q[win_ch]);
            if (!win_we) begin
                a_opcode_o = 3'd4;
            end else if (win_be == '1) begin
                a_opcode_o = 3'd0;
            end else begin
                a_opcode_o = 3'd1;
            end
        end
    end

    // Responses to idle or nonexistent channels are dropped here, which also guards cnt underflow.
    assign rsp_ch = d_source_i >> SlotBits;
    always_comb begin
        rsp_valid = '0;
        for (int c = 0; c < NumCh; c++) begin
            rsp_valid[c] = !rst_i && d_valid_i && (rsp_ch == SrcW'(c)) && (cnt_q[c] != '0);
        end
    end

    assign a_valid_o = a_valid;
    assign gnt_o     = gnt;
    assign valid_o   = rsp_valid;
    assign rdata_o   = (|rsp_valid) ? d_data_i : '0;
    assign err_o     = (|rsp_valid) && d_error_i;
    assign d_ready_o = !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_ARB;
            lock_ch_q <= '0;
            rr_ptr_q  <= '0;
            for (int c = 0; c < NumCh; c++) begin
                cnt_q[c]  <= '0;
                slot_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NumCh; c++) begin
                if (gnt[c] && !rsp_valid[c]) begin
                    cnt_q[c] <= cnt_q[c] + CntW'(1);
                end else if (!gnt[c] && rsp_valid[c]) begin
                    cnt_q[c] <= cnt_q[c] - CntW'(1);
                end
                if (gnt[c]) begin
                    slot_q[c] <= (slot_q[c] == SlotW'(MaxReqs - 1)) ? '0 : slot_q[c] + SlotW'(1);
                end
            end
            if (accept) begin
                rr_ptr_q <= (win_ch == ChW'(NumCh - 1)) ? '0 : win_ch + ChW'(1);
            end
            // A stalled A beat freezes the winner until the slave takes it.
            case (state_q)
                ST_ARB: begin
                    if (a_valid && !a_ready_i) begin
                        state_q   <= ST_LOCK;
                        lock_ch_q <= win_ch;
                    end
                end
                ST_LOCK: begin
                    if (a_ready_i) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

`ifdef BRQ_HOST_MUX_ERRCHK_EN
    logic proto_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            proto_err_q <= 1'b0;
        end else if ((d_valid_i && !(|rsp_valid)) ||
                     ((state_q == ST_LOCK) && !req_i[lock_ch_q])) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err_o = proto_err_q;
`endif

endmodule
